// File: rtl/read_sched_pkg.sv
// Shared field widths and the request record for the VRF read-port scheduler.
package read_sched_pkg;

  localparam int VS_W     = 5;
  localparam int OFFSET_W = 2;
  localparam int GROUP_W  = 4;
  localparam int SOURCE_W = 4;
  localparam int IDX_W    = 3;

  typedef struct packed {
    logic [VS_W-1:0]     vs;
    logic [OFFSET_W-1:0] offset;
    logic [GROUP_W-1:0]  groupIndex;
    logic [SOURCE_W-1:0] readSource;
    logic [IDX_W-1:0]    instructionIndex;
  } read_req_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping; combinational, no backpressure.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  logic [2*N-1:0] dbl;

  always_comb begin
    dbl = {req, req};
    for (int j = 0; j < N; j++) begin
      if (j < int'(ptr)) dbl[j] = 1'b0;
    end
    any       = |req;
    grant_idx = '0;
    // Descending scan so the lowest surviving bit is the final assignment.
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j]) grant_idx = PTR_W'(j % N);
    end
    grant = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/vrf_read_rr_scheduler.sv
// Round-robin VRF read-port arbiter into a 1-entry register: 1-cycle latency, refills while draining, holds under bank stall.
// READ_SCHED_AGE_PRIO_EN restricts competition to requesters with the oldest instructionIndex relative to io_instructionHead.
module vrf_read_rr_scheduler
  import read_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int INDEX_W = IDX_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_flush,
  input  logic [N-1:0]          io_in_valid,
  output logic [N-1:0]          io_in_ready,
  input  logic [N*VS_W-1:0]     io_in_bits_vs,
  input  logic [N*OFFSET_W-1:0] io_in_bits_offset,
  input  logic [N*GROUP_W-1:0]  io_in_bits_groupIndex,
  input  logic [N*SOURCE_W-1:0] io_in_bits_readSource,
  input  logic [N*INDEX_W-1:0]  io_in_bits_instructionIndex,
`ifdef READ_SCHED_AGE_PRIO_EN
  input  logic [INDEX_W-1:0]    io_instructionHead,
`endif
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [VS_W-1:0]       io_out_bits_vs,
  output logic [OFFSET_W-1:0]   io_out_bits_offset,
  output logic [GROUP_W-1:0]    io_out_bits_groupIndex,
  output logic [SOURCE_W-1:0]   io_out_bits_readSource,
  output logic [INDEX_W-1:0]    io_out_bits_instructionIndex,
  output logic [N-1:0]          io_out_grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  if (INDEX_W != IDX_W) begin : g_index_w_check
    $error("INDEX_W must match read_sched_pkg::IDX_W");
  end

  read_req_t        req [N];
  read_req_t        out_q;
  logic [PTR_W-1:0] ptr;
  logic [N-1:0]     pick_mask;
  logic [N-1:0]     win_oh;
  logic [PTR_W-1:0] win_idx;
  logic             win_any;
  logic             accept;
  logic             fire;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i].vs               = io_in_bits_vs[VS_W*i +: VS_W];
      req[i].offset           = io_in_bits_offset[OFFSET_W*i +: OFFSET_W];
      req[i].groupIndex       = io_in_bits_groupIndex[GROUP_W*i +: GROUP_W];
      req[i].readSource       = io_in_bits_readSource[SOURCE_W*i +: SOURCE_W];
      req[i].instructionIndex = io_in_bits_instructionIndex[INDEX_W*i +: INDEX_W];
    end
  end

`ifdef READ_SCHED_AGE_PRIO_EN
  logic [INDEX_W-1:0] age [N];
  logic [INDEX_W-1:0] min_age;

  // Age is the modular distance from the head slot, so wraparound orders correctly.
  always_comb begin
    min_age = '1;
    for (int i = 0; i < N; i++) begin
      age[i] = req[i].instructionIndex - io_instructionHead;
    end
    for (int i = 0; i < N; i++) begin
      if (io_in_valid[i] && (age[i] < min_age)) min_age = age[i];
    end
    for (int i = 0; i < N; i++) begin
      pick_mask[i] = io_in_valid[i] && (age[i] == min_age);
    end
  end
`else
  assign pick_mask = io_in_valid;
`endif

  rr_priority_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req       (pick_mask),
    .ptr       (ptr),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign accept      = !reset && !io_flush && (!io_out_valid || io_out_ready);
  assign fire        = accept && win_any;
  assign io_in_ready = fire ? win_oh : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_valid <= 1'b0;
      out_q        <= '0;
      io_out_grant <= '0;
      ptr          <= '0;
    end else if (fire) begin
      io_out_valid <= 1'b1;
      out_q        <= req[win_idx];
      io_out_grant <= win_oh;
      ptr          <= (win_idx == PTR_W'(N-1)) ? '0 : win_idx + 1'b1;
    end else if (io_flush || io_out_ready) begin
      io_out_valid <= 1'b0;
    end
  end

  assign io_out_bits_vs               = out_q.vs;
  assign io_out_bits_offset           = out_q.offset;
  assign io_out_bits_groupIndex       = out_q.groupIndex;
  assign io_out_bits_readSource       = out_q.readSource;
  assign io_out_bits_instructionIndex = out_q.instructionIndex;

endmodule
